gf_alu: RTL and testbench

GF_ALU -- requirements
Module: gf_alu

---
 rtl/gf_alu.sv | 210 +++++++++++++++++++++
 tb/tb_gf_alu.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gf_alu.sv
// Prime-field ALU: modular add, sub, multiply (MSB-first double-and-add) and
// divide (binary extended inversion). One operation in flight, registered results.
module gf_alu #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned INV_MAX = 2 * WIDTH + 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [WIDTH-1:0] i_prime,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_result,
    output logic             o_err
);
    localparam int unsigned CNT_MAX = (INV_MAX > WIDTH) ? INV_MAX : WIDTH;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, ADDSUB, MUL, INV, DONE} state_t;

    state_t           state_q, state_d;
    logic             sub_q, sub_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic [WIDTH-1:0] u_q, u_d;
    logic [WIDTH-1:0] v_q, v_d;
    logic [WIDTH-1:0] x1_q, x1_d;
    logic [WIDTH-1:0] x2_q, x2_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ready_d, valid_d, oerr_d;
    logic [WIDTH-1:0] result_d;
    logic [WIDTH-1:0] mul_dbl, mul_nxt;

    // (x + y) mod m with a single conditional subtract on WIDTH+1 bits
    function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] m);
        logic [WIDTH:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, m}) begin
            s = s - {1'b0, m};
        end
        return WIDTH'(s);
    endfunction

    function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic [WIDTH-1:0] m);
        logic [WIDTH:0] s;
        if (x >= y) begin
            s = {1'b0, x} - {1'b0, y};
        end else begin
            s = {1'b0, x} + {1'b0, m} - {1'b0, y};
        end
        return WIDTH'(s);
    endfunction

    // x / 2 mod m; odd x is lifted by m first so the shift is exact
    function automatic logic [WIDTH-1:0] halve(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] m);
        logic [WIDTH:0] s;
        s = x[0] ? ({1'b0, x} + {1'b0, m}) : {1'b0, x};
        return WIDTH'(s >> 1);
    endfunction

    // Next-state, datapath and output decode
    always_comb begin
        state_d  = state_q;
        sub_d    = sub_q;
        err_d    = err_q;
        a_d      = a_q;
        b_d      = b_q;
        p_d      = p_q;
        u_d      = u_q;
        v_d      = v_q;
        x1_d     = x1_q;
        x2_d     = x2_q;
        cnt_d    = cnt_q;
        valid_d  = 1'b0;
        oerr_d   = o_err;
        result_d = o_result;
        mul_dbl  = mod_add(x1_q, x1_q, p_q);
        mul_nxt  = a_q[WIDTH-1] ? mod_add(mul_dbl, b_q, p_q) : mul_dbl;

        case (state_q)
            IDLE: begin
                if (i_valid && o_ready) begin
                    a_d   = i_a;
                    b_d   = i_b;
                    p_d   = i_prime;
                    sub_d = i_op[0];
                    err_d = 1'b0;
                    cnt_d = '0;
                    u_d   = i_b;
                    v_d   = i_prime;
                    x2_d  = '0;
                    case (i_op)
                        2'd0, 2'd1: state_d = ADDSUB;
                        2'd2: begin
                            x1_d    = '0;
                            state_d = MUL;
                        end
                        default: begin
                            x1_d = i_a;
                            if (i_b == '0) begin
                                x1_d    = '0;
                                err_d   = 1'b1;
                                state_d = DONE;
                            end else begin
                                state_d = INV;
                            end
                        end
                    endcase
                end
            end
            ADDSUB: begin
                x1_d    = sub_q ? mod_sub(a_q, b_q, p_q) : mod_add(a_q, b_q, p_q);
                state_d = DONE;
            end
            MUL: begin
                x1_d  = mul_nxt;
                a_d   = a_q << 1;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            INV: begin
                // Invariants: x1*b == a*u and x2*b == a*v (mod p)
                if (u_q == WIDTH'(1)) begin
                    state_d = DONE;
                end else if (v_q == WIDTH'(1)) begin
                    x1_d    = x2_q;
                    state_d = DONE;
                end else if (cnt_q == CNT_W'(INV_MAX)) begin
                    x1_d    = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (!u_q[0]) begin
                        u_d  = u_q >> 1;
                        x1_d = halve(x1_q, p_q);
                    end else if (!v_q[0]) begin
                        v_d  = v_q >> 1;
                        x2_d = halve(x2_q, p_q);
                    end else if (u_q >= v_q) begin
                        u_d  = u_q - v_q;
                        x1_d = mod_sub(x1_q, x2_q, p_q);
                    end else begin
                        v_d  = v_q - u_q;
                        x2_d = mod_sub(x2_q, x1_q, p_q);
                    end
                end
            end
            DONE: begin
                valid_d  = 1'b1;
                oerr_d   = err_q;
                result_d = x1_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Ready reopens only after the completion pulse has been seen
        ready_d = (state_d == IDLE) && (state_q != DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= IDLE;
            sub_q    <= 1'b0;
            err_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            p_q      <= '0;
            u_q      <= '0;
            v_q      <= '0;
            x1_q     <= '0;
            x2_q     <= '0;
            cnt_q    <= '0;
            o_ready  <= 1'b1;
            o_valid  <= 1'b0;
            o_err    <= 1'b0;
            o_result <= '0;
        end else begin
            state_q  <= state_d;
            sub_q    <= sub_d;
            err_q    <= err_d;
            a_q      <= a_d;
            b_q      <= b_d;
            p_q      <= p_d;
            u_q      <= u_d;
            v_q      <= v_d;
            x1_q     <= x1_d;
            x2_q     <= x2_d;
            cnt_q    <= cnt_d;
            o_ready  <= ready_d;
            o_valid  <= valid_d;
            o_err    <= oerr_d;
            o_result <= result_d;
        end
    end

endmodule

// File: tb/tb_gf_alu.sv
// Directed bench for gf_alu at WIDTH=32, p = 2^32-5, plus a held-valid
// stream checked against an arithmetic reference.
module tb_gf_alu;
    localparam int unsigned WIDTH   = 32;
    localparam int unsigned INV_MAX = 2 * WIDTH + 2;
    localparam logic [31:0] P       = 32'hFFFF_FFFB;

    typedef struct {
        logic [31:0] res;
        logic        err;
    } exp_t;

    logic        i_clk   = 1'b0;
    logic        i_rst   = 1'b1;
    logic        i_valid = 1'b0;
    logic [1:0]  i_op    = 2'd0;
    logic [31:0] i_a     = '0;
    logic [31:0] i_b     = '0;
    logic [31:0] i_prime = P;
    logic        o_ready;
    logic        o_valid;
    logic [31:0] o_result;
    logic        o_err;

    int checks   = 0;
    int failures = 0;

    gf_alu #(.WIDTH(WIDTH), .INV_MAX(INV_MAX)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_op    (i_op),
        .i_a     (i_a),
        .i_b     (i_b),
        .i_prime (i_prime),
        .o_valid (o_valid),
        .o_result(o_result),
        .o_err   (o_err)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = 33'(a) + 33'(b);
        if (s >= 33'(P)) s = s - 33'(P);
        return 32'(s);
    endfunction

    function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = (a >= b) ? 33'(a) - 33'(b) : 33'(a) + 33'(P) - 33'(b);
        return 32'(s);
    endfunction

    function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
        longint unsigned t;
        t = (64'(a) * 64'(b)) % 64'(P);
        return 32'(t);
    endfunction

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (o_ready !== 1'b1 && guard < 200) begin
            @(negedge i_clk);
            guard++;
        end
    endtask

    // Issue one request; lat = edges from accept to the edge raising o_valid
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output logic err, output int lat);
        wait_ready();
        i_op = op; i_a = a; i_b = b; i_prime = P; i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_op = 2'($urandom); i_a = $urandom; i_b = $urandom; i_prime = $urandom;
        lat = 0;
        while (o_valid !== 1'b1 && lat < int'(INV_MAX) + 8) begin
            @(negedge i_clk);
            lat++;
        end
        res = o_result;
        err = o_err;
    endtask

    task automatic test_reset();
        #2 i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        checks++;
        if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
        checks++;
        if (o_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", o_err); end
        checks++;
        if (o_result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h expected 0", o_result); end
        i_rst = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_addsub();
        logic [1:0]  op [9];
        logic [31:0] va [9];
        logic [31:0] vb [9];
        logic [31:0] ve [9];
        logic [31:0] res;
        logic        err;
        int          lat;
        op = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1};
        va = '{32'hFFFF_FFFA, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'h0, 32'h1234_5678,
               32'h3, 32'h5, 32'h0, 32'h10};
        vb = '{32'h2, 32'h2, 32'hFFFF_FFFA, 32'h0, 32'h1111_1111,
               32'h5, 32'h5, 32'hFFFF_FFFA, 32'h3};
        ve = '{32'h1, 32'h0, 32'hFFFF_FFF9, 32'h0, 32'h2345_6789,
               32'hFFFF_FFF9, 32'h0, 32'h1, 32'hD};
        for (int i = 0; i < 9; i++) begin
            run_op(op[i], va[i], vb[i], res, err, lat);
            checks++;
            if (res !== ve[i] || err !== 1'b0) begin
                failures++;
                $display("FAIL addsub[%0d]: got %h err %b expected %h err 0", i, res, err, ve[i]);
            end
            checks++;
            if (lat != 2) begin failures++; $display("FAIL addsub_lat[%0d]: got %0d expected 2", i, lat); end
        end
    endtask

    task automatic test_mul();
        logic [31:0] va [5];
        logic [31:0] vb [5];
        logic [31:0] ve [5];
        logic [31:0] res;
        logic        err;
        int          lat;
        va = '{32'hFFFF_FFFA, 32'h0, 32'h2, 32'h0001_0000, 32'hFFFF_FFFA};
        vb = '{32'hFFFF_FFFA, 32'h1234, 32'h3, 32'h0001_0000, 32'h2};
        ve = '{32'h1, 32'h0, 32'h6, 32'h5, 32'hFFFF_FFF9};
        for (int i = 0; i < 5; i++) begin
            run_op(2'd2, va[i], vb[i], res, err, lat);
            checks++;
            if (res !== ve[i] || err !== 1'b0) begin
                failures++;
                $display("FAIL mul[%0d]: got %h err %b expected %h err 0", i, res, err, ve[i]);
            end
            checks++;
            if (lat != 33) begin failures++; $display("FAIL mul_lat[%0d]: got %0d expected 33", i, lat); end
        end
    endtask

    task automatic test_div();
        logic [31:0] va [6];
        logic [31:0] vb [6];
        logic [31:0] ve [6];
        logic        vr [6];
        logic [31:0] res;
        logic        err;
        int          lat;
        va = '{32'h1, 32'h1, 32'h8, 32'h7, 32'h7, 32'h1};
        vb = '{32'h2, 32'h3, 32'h4, 32'h1, 32'h0, P};
        ve = '{32'h7FFF_FFFE, 32'h5555_5554, 32'h2, 32'h7, 32'h0, 32'h0};
        vr = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 6; i++) begin
            run_op(2'd3, va[i], vb[i], res, err, lat);
            checks++;
            if (res !== ve[i] || err !== vr[i]) begin
                failures++;
                $display("FAIL div[%0d]: got %h err %b expected %h err %b", i, res, err, ve[i], vr[i]);
            end
            checks++;
            if (lat > int'(INV_MAX) + (vr[i] ? 2 : 1)) begin
                failures++;
                $display("FAIL div_lat[%0d]: got %0d expected at most %0d", i, lat, int'(INV_MAX) + 2);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic        err;
        int          lat;
        run_op(2'd0, 32'd10, 32'd20, res, err, lat);
        checks++;
        if (res !== 32'd30) begin failures++; $display("FAIL b2b_first: got %h expected 1e", res); end
        checks++;
        if (o_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_with_valid: got %b expected 0", o_ready); end
        i_op = 2'd1; i_a = 32'd20; i_b = 32'd30; i_prime = P; i_valid = 1'b1;
        @(negedge i_clk);
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("FAIL b2b_pulse_width: got %b expected 0", o_valid); end
        checks++;
        if (o_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_return: got %b expected 1", o_ready); end
        checks++;
        if (o_result !== 32'd30) begin failures++; $display("FAIL b2b_hold: got %h expected 1e", o_result); end
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        lat = 0;
        while (o_valid !== 1'b1 && lat < 20) begin
            @(negedge i_clk);
            lat++;
        end
        checks++;
        if (o_result !== 32'hFFFF_FFF1 || lat != 2) begin
            failures++;
            $display("FAIL b2b_second: got %h lat %0d expected fffffff1 lat 2", o_result, lat);
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic        err;
        int          lat;
        int          seen;
        wait_ready();
        i_op = 2'd2; i_a = 32'h1234_5678; i_b = 32'h9ABC_DEF0; i_prime = P; i_valid = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        i_valid = 1'b0;
        seen = 0;
        repeat (9) begin
            @(negedge i_clk);
            if (o_valid === 1'b1) seen++;
        end
        i_rst = 1'b0;
        #1;
        checks++;
        if (o_result !== 32'h0 || o_valid !== 1'b0 || o_ready !== 1'b1) begin
            failures++;
            $display("FAIL midreset_state: got result %h valid %b ready %b expected 0 0 1", o_result, o_valid, o_ready);
        end
        repeat (2) @(negedge i_clk);
        i_rst = 1'b1;
        repeat (40) begin
            @(negedge i_clk);
            if (o_valid === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin failures++; $display("FAIL midreset_no_valid: got %0d pulses expected 0", seen); end
        run_op(2'd0, 32'd1, 32'd1, res, err, lat);
        checks++;
        if (res !== 32'd2 || err !== 1'b0 || lat != 2) begin
            failures++;
            $display("FAIL midreset_after: got %h err %b lat %0d expected 2 err 0 lat 2", res, err, lat);
        end
    endtask

    // i_valid held high with ops changing every cycle; one accept per idle visit
    task automatic test_hold_valid();
        exp_t        q[$];
        exp_t        e;
        exp_t        nxt;
        logic [31:0] bt  [5];
        logic [31:0] inv [5];
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          idx;
        int          acc_n;
        int          done_n;
        bt  = '{32'h0, 32'h1, 32'h2, 32'h3, 32'h4};
        inv = '{32'h0, 32'h1, 32'h7FFF_FFFE, 32'h5555_5554, 32'h0};
        inv[4] = ref_mul(32'h7FFF_FFFE, 32'h7FFF_FFFE);
        acc_n  = 0;
        done_n = 0;
        wait_ready();
        for (int cyc = 0; cyc < 5000; cyc++) begin
            if (o_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL hold_spurious: got valid with result %h expected no completion", o_result);
                end else begin
                    e = q.pop_front();
                    done_n++;
                    if (o_result !== e.res || o_err !== e.err) begin
                        failures++;
                        $display("FAIL hold[%0d]: got %h err %b expected %h err %b", done_n, o_result, o_err, e.res, e.err);
                    end
                end
            end
            op = 2'($urandom_range(0, 3));
            a  = $urandom % P;
            b  = $urandom % P;
            nxt.err = 1'b0;
            case (op)
                2'd0: nxt.res = ref_add(a, b);
                2'd1: nxt.res = ref_sub(a, b);
                2'd2: nxt.res = ref_mul(a, b);
                default: begin
                    idx     = $urandom_range(0, 4);
                    b       = bt[idx];
                    nxt.res = ref_mul(a, inv[idx]);
                    if (idx == 0) begin
                        nxt.res = 32'h0;
                        nxt.err = 1'b1;
                    end
                end
            endcase
            i_op = op; i_a = a; i_b = b; i_prime = P; i_valid = 1'b1;
            if (o_ready === 1'b1) begin
                q.push_back(nxt);
                acc_n++;
            end
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            if (o_valid === 1'b1) begin
                checks++;
                if (q.size() == 0) begin
                    failures++;
                    $display("FAIL hold_drain_spurious: got valid with result %h expected none", o_result);
                end else begin
                    e = q.pop_front();
                    done_n++;
                    if (o_result !== e.res || o_err !== e.err) begin
                        failures++;
                        $display("FAIL hold_drain: got %h err %b expected %h err %b", o_result, o_err, e.res, e.err);
                    end
                end
            end
            @(negedge i_clk);
        end
        checks++;
        if (done_n != acc_n || acc_n < 50) begin
            failures++;
            $display("FAIL hold_count: got %0d completions for %0d accepts expected equal and at least 50", done_n, acc_n);
        end
    endtask

    initial begin
        test_reset();
        test_addsub();
        test_mul();
        test_div();
        test_back_to_back();
        test_reset_mid();
        test_hold_valid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
